// File: rtl/mux3_rr_if.sv
// rtl/mux3_rr_if.sv - requester/consumer bundle for the 3:1 round-robin mux arbiter
//
// Signals:
//   req_valid[2:0], req_last[2:0]   per-requester beat valid / last flag
//   req_data0..2 [WIDTH-1:0]        requester data (mux inputs I0..I2)
//   req_ready[2:0]                  per-requester accept, at most one bit high
//   out_valid, out_data, out_last   muxed beat towards the consumer
//   out_ready                       consumer accept
//   sel[1:0], grant[2:0]            registered mux select and one-hot grant
// Modports: master = arbiter side, slave = requester/consumer side.
interface mux3_rr_if #(
    parameter int WIDTH = 8
);
    logic [2:0]       req_valid;
    logic [2:0]       req_last;
    logic [WIDTH-1:0] req_data0;
    logic [WIDTH-1:0] req_data1;
    logic [WIDTH-1:0] req_data2;
    logic [2:0]       req_ready;
    logic             out_valid;
    logic [WIDTH-1:0] out_data;
    logic             out_last;
    logic             out_ready;
    logic [1:0]       sel;
    logic [2:0]       grant;

    modport master (
        input  req_valid, req_last, req_data0, req_data1, req_data2, out_ready,
        output req_ready, out_valid, out_data, out_last, sel, grant
    );

    modport slave (
        output req_valid, req_last, req_data0, req_data1, req_data2, out_ready,
        input  req_ready, out_valid, out_data, out_last, sel, grant
    );
endinterface

// File: rtl/mux3_rr_arbiter.sv
// rtl/mux3_rr_arbiter.sv - round-robin arbiter and sequencer owning a 3:1 packet mux select
//
// Parameters: WIDTH (data width), MAX_BEATS (beats per grant before forced release, >= 1)
// Ports:
//   clk   clock, all state changes on the rising edge
//   rst   synchronous active-high reset
//   bus   mux3_rr_if.master: requester streams in, muxed stream out, sel/grant out
module mux3_rr_arbiter #(
    parameter int WIDTH     = 8,
    parameter int MAX_BEATS = 16
) (
    input  logic          clk,
    input  logic          rst,
    mux3_rr_if.master     bus
);
    localparam int CNT_W = (MAX_BEATS > 1) ? $clog2(MAX_BEATS) : 1;
    localparam logic [CNT_W-1:0] LIMIT = CNT_W'(MAX_BEATS - 1);

    typedef enum logic {IDLE, BUSY} state_t;

    state_t           state, state_d;
    logic [1:0]       sel, sel_d;
    logic [2:0]       grant, grant_d;
    logic [1:0]       last_idx, last_idx_d;
    logic [CNT_W-1:0] cnt, cnt_d;

    logic             mux_valid;
    logic             mux_last;
    logic [WIDTH-1:0] mux_data;
    logic             win_found;
    logic [1:0]       win_idx;
    logic [2:0]       win_onehot;
    logic             at_limit;
    logic             xfer;

    // The 3:1 mux itself; sel=11 never happens, it aliases to input 0.
    always_comb begin
        case (sel)
            2'd1: begin
                mux_valid = bus.req_valid[1];
                mux_last  = bus.req_last[1];
                mux_data  = bus.req_data1;
            end
            2'd2: begin
                mux_valid = bus.req_valid[2];
                mux_last  = bus.req_last[2];
                mux_data  = bus.req_data2;
            end
            default: begin
                mux_valid = bus.req_valid[0];
                mux_last  = bus.req_last[0];
                mux_data  = bus.req_data0;
            end
        endcase
    end

    // Round-robin search starting just after the previous winner.
    always_comb begin
        win_found = |bus.req_valid;
        win_idx   = 2'd0;
        case (last_idx)
            2'd0: begin
                if (bus.req_valid[1])      win_idx = 2'd1;
                else if (bus.req_valid[2]) win_idx = 2'd2;
                else                       win_idx = 2'd0;
            end
            2'd1: begin
                if (bus.req_valid[2])      win_idx = 2'd2;
                else if (bus.req_valid[0]) win_idx = 2'd0;
                else                       win_idx = 2'd1;
            end
            default: begin
                if (bus.req_valid[0])      win_idx = 2'd0;
                else if (bus.req_valid[1]) win_idx = 2'd1;
                else                       win_idx = 2'd2;
            end
        endcase
        case (win_idx)
            2'd1:    win_onehot = 3'b010;
            2'd2:    win_onehot = 3'b100;
            default: win_onehot = 3'b001;
        endcase
    end

    assign at_limit = (cnt == LIMIT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            sel      <= 2'd0;
            grant    <= 3'b000;
            last_idx <= 2'd2;
            cnt      <= '0;
        end else begin
            state    <= state_d;
            sel      <= sel_d;
            grant    <= grant_d;
            last_idx <= last_idx_d;
            cnt      <= cnt_d;
        end
    end

    always_comb begin
        state_d       = state;
        sel_d         = sel;
        grant_d       = grant;
        last_idx_d    = last_idx;
        cnt_d         = cnt;
        xfer          = 1'b0;
        bus.out_valid = 1'b0;
        bus.out_last  = 1'b0;
        bus.req_ready = 3'b000;
        case (state)
            IDLE: begin
                if (win_found) begin
                    sel_d   = win_idx;
                    grant_d = win_onehot;
                    cnt_d   = '0;
                    state_d = BUSY;
                end
            end
            BUSY: begin
                bus.out_valid = mux_valid;
                bus.out_last  = mux_last | at_limit;
                // grant is one-hot of sel while busy, so it steers ready directly.
                bus.req_ready = grant & {3{bus.out_ready}};
                xfer          = mux_valid & bus.out_ready;
                if (xfer) begin
                    if (mux_last || at_limit) begin
                        state_d    = IDLE;
                        last_idx_d = sel;
                        grant_d    = 3'b000;
                    end else begin
                        cnt_d = cnt + 1'b1;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign bus.out_data = mux_data;
    assign bus.sel      = sel;
    assign bus.grant    = grant;
endmodule

// File: tb/tb_mux3_rr_arbiter.sv
// tb/tb_mux3_rr_arbiter.sv - directed self-checking bench for mux3_rr_arbiter
module tb_mux3_rr_arbiter;
    logic clk;
    logic rst;
    int   checks;
    int   failures;

    mux3_rr_if #(.WIDTH(8)) bus ();

    mux3_rr_arbiter #(.WIDTH(8), .MAX_BEATS(4)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(negedge clk);
    endtask

    task automatic do_reset();
        step();
        rst           = 1'b1;
        bus.req_valid = 3'b000;
        bus.req_last  = 3'b000;
        bus.req_data0 = 8'h00;
        bus.req_data1 = 8'h00;
        bus.req_data2 = 8'h00;
        bus.out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        #1;
        checks++;
        if (bus.grant !== 3'b000) begin
            failures++; $display("FAIL reset_grant got=%b exp=000", bus.grant);
        end
        checks++;
        if (bus.sel !== 2'b00) begin
            failures++; $display("FAIL reset_sel got=%b exp=00", bus.sel);
        end
        checks++;
        if (bus.out_valid !== 1'b0 || bus.out_last !== 1'b0 || bus.req_ready !== 3'b000) begin
            failures++;
            $display("FAIL reset_outputs got valid=%b last=%b ready=%b exp 0 0 000",
                     bus.out_valid, bus.out_last, bus.req_ready);
        end
    endtask

    task automatic test_reset_priority();
        logic [1:0] exp_sel [4];
        logic [7:0] exp_data;
        exp_sel = '{2'd0, 2'd1, 2'd2, 2'd0};
        do_reset();
        bus.req_valid = 3'b111;
        bus.req_last  = 3'b111;
        bus.out_ready = 1'b1;
        bus.req_data0 = 8'hA0;
        bus.req_data1 = 8'hB1;
        bus.req_data2 = 8'hC2;
        #1;
        checks++;
        if (bus.out_valid !== 1'b0) begin
            failures++; $display("FAIL prio_first_idle got out_valid=%b exp=0", bus.out_valid);
        end
        for (int i = 0; i < 4; i++) begin
            exp_data = (exp_sel[i] == 2'd0) ? 8'hA0 : (exp_sel[i] == 2'd1) ? 8'hB1 : 8'hC2;
            step(); #1;
            checks++;
            if (bus.grant !== (3'b001 << exp_sel[i]) || bus.sel !== exp_sel[i]) begin
                failures++;
                $display("FAIL prio_grant[%0d] got grant=%b sel=%b exp grant=%b sel=%b",
                         i, bus.grant, bus.sel, 3'b001 << exp_sel[i], exp_sel[i]);
            end
            checks++;
            if (bus.out_valid !== 1'b1 || bus.out_last !== 1'b1 || bus.out_data !== exp_data ||
                bus.req_ready !== (3'b001 << exp_sel[i])) begin
                failures++;
                $display("FAIL prio_beat[%0d] got v=%b l=%b d=%h r=%b exp v=1 l=1 d=%h r=%b",
                         i, bus.out_valid, bus.out_last, bus.out_data, bus.req_ready,
                         exp_data, 3'b001 << exp_sel[i]);
            end
            step(); #1;
            checks++;
            if (bus.grant !== 3'b000 || bus.out_valid !== 1'b0 || bus.req_ready !== 3'b000 ||
                bus.sel !== exp_sel[i]) begin
                failures++;
                $display("FAIL prio_bubble[%0d] got grant=%b v=%b r=%b sel=%b exp 000 0 000 %b",
                         i, bus.grant, bus.out_valid, bus.req_ready, bus.sel, exp_sel[i]);
            end
        end
    endtask

    task automatic test_packet_hold();
        do_reset();
        bus.req_valid = 3'b011;
        bus.req_last  = 3'b000;
        bus.out_ready = 1'b1;
        bus.req_data1 = 8'h77;
        for (int b = 0; b < 3; b++) begin
            step();
            bus.req_data0   = 8'h10 + 8'(b);
            bus.req_last[0] = (b == 2);
            #1;
            checks++;
            if (bus.grant !== 3'b001 || bus.req_ready !== 3'b001 || bus.out_data !== 8'h10 + 8'(b) ||
                bus.out_last !== (b == 2)) begin
                failures++;
                $display("FAIL hold_beat[%0d] got grant=%b r=%b d=%h l=%b exp 001 001 %h %b",
                         b, bus.grant, bus.req_ready, bus.out_data, bus.out_last,
                         8'h10 + 8'(b), (b == 2));
            end
        end
        step(); #1;
        checks++;
        if (bus.grant !== 3'b000) begin
            failures++; $display("FAIL hold_release got grant=%b exp=000", bus.grant);
        end
        step(); #1;
        checks++;
        if (bus.grant !== 3'b010 || bus.sel !== 2'b01 || bus.out_data !== 8'h77) begin
            failures++;
            $display("FAIL hold_next got grant=%b sel=%b d=%h exp 010 01 77",
                     bus.grant, bus.sel, bus.out_data);
        end
    endtask

    task automatic test_forced_release();
        do_reset();
        bus.req_valid = 3'b100;
        bus.req_last  = 3'b000;
        bus.out_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            step();
            bus.req_data2 = 8'hC0 + 8'(b);
            #1;
            checks++;
            if (bus.grant !== 3'b100 || bus.sel !== 2'b10 || bus.out_last !== (b == 3) ||
                bus.out_data !== 8'hC0 + 8'(b)) begin
                failures++;
                $display("FAIL forced_beat[%0d] got grant=%b sel=%b l=%b d=%h exp 100 10 %b %h",
                         b, bus.grant, bus.sel, bus.out_last, bus.out_data, (b == 3),
                         8'hC0 + 8'(b));
            end
        end
        step(); #1;
        checks++;
        if (bus.grant !== 3'b000 || bus.out_valid !== 1'b0) begin
            failures++;
            $display("FAIL forced_release got grant=%b v=%b exp 000 0", bus.grant, bus.out_valid);
        end
        step(); #1;
        checks++;
        if (bus.grant !== 3'b100 || bus.out_last !== 1'b0) begin
            failures++;
            $display("FAIL forced_regrant got grant=%b l=%b exp 100 0", bus.grant, bus.out_last);
        end
    endtask

    task automatic test_backpressure();
        logic rdy_seq  [7];
        logic vld_seq  [7];
        logic last_exp [7];
        int   xfers;
        rdy_seq  = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
        vld_seq  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1};
        last_exp = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
        xfers    = 0;
        do_reset();
        bus.req_valid = 3'b010;
        bus.req_last  = 3'b000;
        for (int c = 0; c < 7; c++) begin
            step();
            bus.req_valid[1] = vld_seq[c];
            bus.out_ready    = rdy_seq[c];
            bus.req_data1    = 8'h40 + 8'(c);
            #1;
            checks++;
            if (bus.grant !== 3'b010 || bus.out_valid !== vld_seq[c] ||
                bus.req_ready !== {1'b0, rdy_seq[c], 1'b0} || bus.out_data !== 8'h40 + 8'(c) ||
                bus.out_last !== last_exp[c]) begin
                failures++;
                $display("FAIL bp_cycle[%0d] got g=%b v=%b r=%b d=%h l=%b exp 010 %b %b %h %b",
                         c, bus.grant, bus.out_valid, bus.req_ready, bus.out_data, bus.out_last,
                         vld_seq[c], {1'b0, rdy_seq[c], 1'b0}, 8'h40 + 8'(c), last_exp[c]);
            end
            if (bus.out_valid === 1'b1 && bus.req_ready[1] === 1'b1) xfers++;
        end
        checks++;
        if (xfers != 4) begin
            failures++; $display("FAIL bp_xfer_count got=%0d exp=4", xfers);
        end
        step(); #1;
        checks++;
        if (bus.grant !== 3'b000) begin
            failures++; $display("FAIL bp_release got grant=%b exp=000", bus.grant);
        end
    endtask

    task automatic test_reset_mid_packet();
        do_reset();
        bus.req_valid = 3'b001;
        bus.req_last  = 3'b001;
        bus.out_ready = 1'b1;
        step();
        step();
        bus.req_valid = 3'b010;
        bus.req_last  = 3'b000;
        step(); #1;
        checks++;
        if (bus.grant !== 3'b010) begin
            failures++; $display("FAIL midrst_pregrant got grant=%b exp=010", bus.grant);
        end
        step();
        rst           = 1'b1;
        bus.req_valid = 3'b111;
        step(); #1;
        checks++;
        if (bus.grant !== 3'b000 || bus.sel !== 2'b00 || bus.out_valid !== 1'b0 ||
            bus.req_ready !== 3'b000) begin
            failures++;
            $display("FAIL midrst_state got grant=%b sel=%b v=%b r=%b exp 000 00 0 000",
                     bus.grant, bus.sel, bus.out_valid, bus.req_ready);
        end
        rst = 1'b0;
        step(); #1;
        checks++;
        if (bus.grant !== 3'b001 || bus.sel !== 2'b00) begin
            failures++;
            $display("FAIL midrst_regrant got grant=%b sel=%b exp 001 00", bus.grant, bus.sel);
        end
    endtask

    task automatic test_idle_output();
        do_reset();
        bus.req_valid = 3'b000;
        bus.req_last  = 3'b111;
        for (int c = 0; c < 10; c++) begin
            step();
            bus.out_ready = c[0];
            #1;
            checks++;
            if (bus.out_valid !== 1'b0 || bus.req_ready !== 3'b000 || bus.grant !== 3'b000) begin
                failures++;
                $display("FAIL idle[%0d] got v=%b r=%b g=%b exp 0 000 000",
                         c, bus.out_valid, bus.req_ready, bus.grant);
            end
        end
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst      = 1'b1;
        test_reset();
        test_reset_priority();
        test_packet_hold();
        test_forced_release();
        test_backpressure();
        test_reset_mid_packet();
        test_idle_output();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
